spi_xip_bridge: RTL and testbench

- APB slave that fronts an SPI master core's register port and provides execute-in-place (XIP) reads from serial NOR flash.
- APB reads in the flash window are turned into a fixed register-write/poll/read sequence on the SPI master.
- APB accesses in the SPI-register window pass straight through.
- Generalises the fixed single-purpose flash front end: parametrised command, address width, divider, slave select, byte order and poll timeout; flash-window writes return a bus error.

---
 rtl/spi_xip_bridge.sv | 157 +++++++++++++++
 tb/tb_spi_xip_bridge.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/spi_xip_bridge.sv
// spi_xip_bridge: APB slave fronting an SPI master register port with XIP flash reads
module spi_xip_bridge #(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_MASK = 32'hF000_0000,
  parameter logic [31:0] SPI_BASE   = 32'h1000_1000,
  parameter int          ADDR_BITS  = 24,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [15:0] DIVIDER    = 16'd1,
  parameter int          SS_INDEX   = 0,
  parameter bit          SWAP_BYTES = 1'b1,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic [4:0]  reg_adr,
  output logic [31:0] reg_dat_w,
  input  logic [31:0] reg_dat_r,
  output logic [3:0]  reg_sel,
  output logic        reg_we,
  output logic        reg_stb,
  input  logic        reg_ack,
  output logic        busy
);
  localparam int CW = $clog2(POLL_LIMIT + 1);
  typedef enum logic [3:0] {IDLE, ERR, PASS, TX1, DIV, SS, LEN, GO, POLL, RX, CLR, CLRE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [23:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n, data_q, data_n, prdata_n, dat_n, op_dat, rx_word;
  logic [3:0] strb_q, strb_n, sel_n, op_sel;
  logic [4:0] adr_n, op_adr;
  logic write_q, write_n, pready_n, pslverr_n, we_n, stb_n, op_we, flash_hit, spi_hit;
  assign busy = state != IDLE;
  assign flash_hit = (paddr & FLASH_MASK) == FLASH_BASE;
  assign spi_hit = paddr[31:5] == SPI_BASE[31:5];
  assign rx_word = SWAP_BYTES ? {reg_dat_r[7:0], reg_dat_r[15:8], reg_dat_r[23:16], reg_dat_r[31:24]} : reg_dat_r;
  // Register operation issued by each step of the pass-through and XIP sequences
  always_comb begin
    op_adr = 5'h10;
    op_we = 1'b1;
    op_sel = 4'hF;
    op_dat = 32'h0;
    case (state)
      PASS: begin op_adr = addr_q[4:0]; op_we = write_q; op_sel = strb_q; op_dat = wdata_q; end
      TX1: begin op_adr = 5'h04; op_dat = {READ_CMD, 24'(addr_q[ADDR_BITS-1:0])}; end
      DIV: begin op_adr = 5'h14; op_dat = 32'(DIVIDER); end
      SS: begin op_adr = 5'h18; op_dat = 32'd1 << SS_INDEX; end
      LEN: op_dat = 32'h40;
      GO: op_dat = 32'h140;
      POLL: op_we = 1'b0;
      RX: begin op_adr = 5'h00; op_we = 1'b0; end
      CLR, CLRE: op_adr = 5'h18;
      default: ;
    endcase
  end
  // Next state, request handshake and APB response
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = addr_q;
    wdata_n = wdata_q;
    strb_n = strb_q;
    write_n = write_q;
    data_n = data_q;
    stb_n = reg_stb;
    adr_n = reg_adr;
    dat_n = reg_dat_w;
    sel_n = reg_sel;
    we_n = reg_we;
    pready_n = 1'b0;
    pslverr_n = 1'b0;
    prdata_n = 32'h0;
    case (state)
      IDLE: if (psel && penable) begin
        addr_n = paddr[23:0];
        wdata_n = pwdata;
        strb_n = pstrb;
        write_n = pwrite;
        cnt_n = '0;
        state_n = flash_hit ? (pwrite ? ERR : TX1) : spi_hit ? PASS : ERR;
      end
      ERR: begin pready_n = 1'b1; pslverr_n = 1'b1; state_n = DONE; end
      DONE: state_n = IDLE;
      default: if (!reg_stb) begin
        stb_n = 1'b1;
        adr_n = op_adr;
        dat_n = op_dat;
        sel_n = op_sel;
        we_n = op_we;
      end else if (reg_ack) begin
        stb_n = 1'b0;
        case (state)
          PASS: begin pready_n = 1'b1; prdata_n = write_q ? 32'h0 : reg_dat_r; state_n = DONE; end
          TX1: state_n = DIV;
          DIV: state_n = SS;
          SS: state_n = LEN;
          LEN: state_n = GO;
          GO: state_n = POLL;
          POLL: if (!reg_dat_r[8]) state_n = RX;
          else begin
            cnt_n = cnt + 1'b1;
            state_n = cnt == CW'(POLL_LIMIT - 1) ? CLRE : POLL;
          end
          RX: begin data_n = rx_word; state_n = CLR; end
          CLR: begin pready_n = 1'b1; prdata_n = data_q; state_n = DONE; end
          CLRE: begin pready_n = 1'b1; pslverr_n = 1'b1; state_n = DONE; end
          default: ;
        endcase
      end
    endcase
  end
  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      write_q <= 1'b0;
      data_q <= '0;
      reg_stb <= 1'b0;
      reg_adr <= '0;
      reg_dat_w <= '0;
      reg_sel <= '0;
      reg_we <= 1'b0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr_q <= addr_n;
      wdata_q <= wdata_n;
      strb_q <= strb_n;
      write_q <= write_n;
      data_q <= data_n;
      reg_stb <= stb_n;
      reg_adr <= adr_n;
      reg_dat_w <= dat_n;
      reg_sel <= sel_n;
      reg_we <= we_n;
      pready <= pready_n;
      pslverr <= pslverr_n;
      prdata <= prdata_n;
    end
  end
endmodule

// File: tb/tb_spi_xip_bridge.sv
// tb_spi_xip_bridge: scoreboard bench for spi_xip_bridge with a small SPI master register model
module tb_spi_xip_bridge;
  logic clock, reset, psel, penable, pwrite, pready, pslverr, reg_we, reg_stb, reg_ack, busy;
  logic [31:0] paddr, pwdata, prdata, reg_dat_w, reg_dat_r;
  logic [3:0] pstrb, reg_sel;
  logic [4:0] reg_adr;
  typedef struct { logic [4:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; } op_t;
  typedef struct { logic [31:0] d; logic e; } rsp_t;
  op_t exp_ops[$];
  rsp_t exp_rsp[$];
  logic [31:0] ctrl_q[$];
  logic [31:0] ctrl_default, rx0;
  int checks, passes, ops_seen, pready_cnt, lat, snap;
  logic prev_pready;

  spi_xip_bridge #(.POLL_LIMIT(4)) dut (
    .clock(clock), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .reg_adr(reg_adr), .reg_dat_w(reg_dat_w), .reg_dat_r(reg_dat_r),
    .reg_sel(reg_sel), .reg_we(reg_we), .reg_stb(reg_stb), .reg_ack(reg_ack), .busy(busy)
  );

  initial begin clock = 0; forever #5 clock = ~clock; end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic push_op(input logic [4:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
    op_t o;
    o.adr = adr; o.we = we; o.dat = dat; o.sel = sel;
    exp_ops.push_back(o);
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e);
    rsp_t r;
    r.d = d; r.e = e;
    exp_rsp.push_back(r);
  endtask

  task automatic push_xip(input logic [31:0] a, input int polls, input bit rx);
    push_op(5'h04, 1, {8'h03, a[23:0]}, 4'hF);
    push_op(5'h14, 1, 32'h1, 4'hF);
    push_op(5'h18, 1, 32'h1, 4'hF);
    push_op(5'h10, 1, 32'h40, 4'hF);
    push_op(5'h10, 1, 32'h140, 4'hF);
    for (int i = 0; i < polls; i++) push_op(5'h10, 0, 32'h0, 4'hF);
    if (rx) push_op(5'h00, 0, 32'h0, 4'hF);
    push_op(5'h18, 1, 32'h0, 4'hF);
  endtask

  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int n);
    @(posedge clock); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clock); #1;
    penable = 1;
    n = 0;
    while (n < 300) begin
      @(posedge clock); #1;
      n++;
      if (pready) break;
    end
    if (!pready) check("apb_timeout", 64'(n), 64'd0);
    psel = 0; penable = 0;
  endtask

  // SPI master model: acks each request one cycle after it appears
  initial begin
    reg_ack = 0; reg_dat_r = 0;
    forever begin
      @(posedge clock); #1;
      if (reg_ack || reset) reg_ack = 0;
      else if (reg_stb) begin
        reg_ack = 1;
        if (reg_we) reg_dat_r = 32'hFFFF_FFFF;
        else if (reg_adr == 5'h10) reg_dat_r = ctrl_q.size() > 0 ? ctrl_q.pop_front() : ctrl_default;
        else if (reg_adr == 5'h00) reg_dat_r = rx0;
        else reg_dat_r = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: compares register ops and APB responses against the scoreboard
  initial begin
    prev_pready = 0;
    forever begin
      @(negedge clock);
      if (!reset && reg_stb && reg_ack) begin
        ops_seen++;
        if (exp_ops.size() == 0) check("op_unexpected", {59'h0, reg_adr}, 64'hFFFF);
        else begin
          op_t e;
          e = exp_ops.pop_front();
          check("reg_op", {22'h0, reg_adr, reg_we, reg_sel, e.we ? reg_dat_w : 32'h0},
                {22'h0, e.adr, e.we, e.sel, e.we ? e.dat : 32'h0});
        end
      end
      if (pready) begin
        pready_cnt++;
        if (exp_rsp.size() == 0) check("rsp_unexpected", {31'h0, pslverr, prdata}, 64'hFFFF);
        else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("apb_rsp", {31'h0, pslverr, prdata}, {31'h0, r.e, r.d});
        end
      end else check("rsp_idle_zero", {31'h0, pslverr, prdata}, 64'h0);
      if (prev_pready) check("pready_pulse", 64'(pready), 64'd0);
      prev_pready = pready;
    end
  end

  initial begin
    checks = 0; passes = 0; ops_seen = 0; pready_cnt = 0;
    reset = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
    ctrl_default = 32'h40; rx0 = 32'h4433_2211;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("reset_idle", {pready, pslverr, prdata, reg_stb, reg_we, reg_adr, reg_dat_w, reg_sel, busy}, 64'h0);
    end
    ctrl_q.push_back(32'h140); ctrl_q.push_back(32'h140);
    push_xip(32'h3000_0104, 3, 1);
    push_rsp(32'h1122_3344, 0);
    apb(0, 32'h3000_0104, 0, 4'hF, lat);
    snap = ops_seen;
    push_rsp(32'h0, 1);
    apb(1, 32'h3000_0000, 32'h1234, 4'hF, lat);
    check("err_latency", 64'(lat), 64'd2);
    push_rsp(32'h0, 1);
    apb(0, 32'h2000_0000, 0, 4'hF, lat);
    check("nohit_latency", 64'(lat), 64'd2);
    @(posedge clock); #1;
    check("err_no_reg_op", 64'(ops_seen - snap), 64'd0);
    push_op(5'h14, 1, 32'h5, 4'h3);
    push_rsp(32'h0, 0);
    apb(1, 32'h1000_1014, 32'h5, 4'h3, lat);
    ctrl_q.push_back(32'h140);
    push_op(5'h10, 0, 32'h0, 4'hF);
    push_rsp(32'h140, 0);
    apb(0, 32'h1000_1010, 0, 4'hF, lat);
    ctrl_default = 32'h140;
    push_xip(32'h3000_0010, 4, 0);
    push_rsp(32'h0, 1);
    apb(0, 32'h3000_0010, 0, 4'hF, lat);
    push_xip(32'h3000_0020, 1, 0);
    @(posedge clock); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h3000_0020;
    @(posedge clock); #1;
    penable = 1;
    lat = 0;
    while (lat < 100 && !(reg_stb && reg_adr == 5'h10 && !reg_we)) begin @(posedge clock); #1; lat++; end
    check("reached_poll", 64'(lat < 100), 64'd1);
    reset = 1; psel = 0; penable = 0;
    snap = pready_cnt;
    @(posedge clock); #1;
    check("mid_reset_outputs", {reg_stb, busy, pready}, 64'h0);
    reset = 0;
    exp_ops.delete();
    repeat (10) @(posedge clock);
    #1 check("mid_reset_no_pready", 64'(pready_cnt - snap), 64'd0);
    ctrl_default = 32'h40; rx0 = 32'hA1B2_C3D4;
    push_xip(32'h3000_0008, 1, 1);
    push_rsp(32'hD4C3_B2A1, 0);
    apb(0, 32'h3000_0008, 0, 4'hF, lat);
    repeat (5) @(posedge clock);
    check("ops_drained", 64'(exp_ops.size()), 64'd0);
    check("rsp_drained", 64'(exp_rsp.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
